l15_req_arbiter: RTL and testbench

Arbitrates the six request sources of the Sargantana tile (I$ miss/BROM, D$ miss-read, D$ write-buffer, uncached read, uncached write, AMO) onto the single OpenPiton L1.5 request channel. Sits between the HPDcache/I$ request ports and the L1.5 request packer in the tile wrapper. Uses fixed priority with age-based starvation escape and per-port outstanding-transaction credits. Holds each issued request stable until the L1.5 header acknowledge.

---
 rtl/sargantana_hpdc_pkg.sv | 24 ++
 rtl/l15_arb_prio_sel.sv | 43 ++++
 rtl/l15_req_arbiter.sv | 174 +++++++++++++++++
 tb/tb_l15_req_arbiter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/sargantana_hpdc_pkg.sv
// Shared definitions for the Sargantana tile HPDcache/L1.5 glue.
// Provides the request-source port indices used by the L1.5 request
// arbiter and the tile wrapper, the port-id type, and the arbiter FSM
// state encoding.
package sargantana_hpdc_pkg;

    localparam int unsigned NUM_REQ_PORTS = 6;

    // Request sources, in descending fixed priority.
    localparam int unsigned ICACHE    = 0;
    localparam int unsigned DCACHE    = 1;
    localparam int unsigned WBUF      = 2;
    localparam int unsigned UNC_READ  = 3;
    localparam int unsigned UNC_WRITE = 4;
    localparam int unsigned AMO       = 5;

    typedef logic [$clog2(NUM_REQ_PORTS)-1:0] req_portid_t;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_ISSUE = 1'b1
    } arb_state_e;

endpackage

// File: rtl/l15_arb_prio_sel.sv
// Two-level fixed-priority picker for the L1.5 request arbiter.
// If any port is both eligible and urgent, the lowest-index such port wins;
// otherwise the lowest-index eligible port wins.
// Ports:
//   eligible_i  - per-port eligibility (valid and credit available)
//   urgent_i    - per-port aging-saturated flag
//   gnt_o       - one-hot grant, zero when nothing is eligible
//   gnt_idx_o   - index of the granted port (0 when no grant)
//   gnt_valid_o - a grant exists this cycle
module l15_arb_prio_sel
    import sargantana_hpdc_pkg::*;
#(
    parameter int unsigned NumPorts = 6,
    parameter int unsigned IdxW     = (NumPorts > 1) ? $clog2(NumPorts) : 1
) (
    input  logic [NumPorts-1:0] eligible_i,
    input  logic [NumPorts-1:0] urgent_i,
    output logic [NumPorts-1:0] gnt_o,
    output logic [IdxW-1:0]     gnt_idx_o,
    output logic                gnt_valid_o
);

    logic [NumPorts-1:0] urg_elig;
    logic [NumPorts-1:0] cand;

    always_comb begin
        urg_elig    = eligible_i & urgent_i;
        // Urgent candidates mask out all non-urgent ones so a starving
        // low-priority port cannot be overtaken by port 0 indefinitely.
        cand        = (|urg_elig) ? urg_elig : eligible_i;
        gnt_o       = '0;
        gnt_idx_o   = '0;
        gnt_valid_o = 1'b0;
        for (int i = 0; i < int'(NumPorts); i++) begin
            if (cand[i] && !gnt_valid_o) begin
                gnt_valid_o = 1'b1;
                gnt_o[i]    = 1'b1;
                gnt_idx_o   = IdxW'(i);
            end
        end
    end

endmodule

// File: rtl/l15_req_arbiter.sv
// Arbitrates the tile request sources onto the single OpenPiton L1.5
// request channel. Fixed priority (port 0 highest) with an age-based
// starvation escape, per-port outstanding-transaction credits, and a
// registered request held stable until the L1.5 header acknowledge.
// Ports:
//   clk_i, rst_i    - clock, synchronous active-high reset
//   req_valid_i     - per-port request valid
//   req_ready_o     - per-port accept (one-hot or zero, only in IDLE)
//   req_payload_i   - packed per-port payloads, port p at [p*PayloadWidth +: PayloadWidth]
//   l15_val_o       - request valid towards the L1.5
//   l15_payload_o   - registered payload of the issued request
//   l15_portid_o    - source port of the issued request
//   l15_ack_i       - L1.5 header acknowledge pulse
//   rtrn_valid_i    - L1.5 return completing one transaction
//   rtrn_portid_i   - port the return belongs to
//   urgent_o        - per-port aging-saturated flag
//   err_o           - sticky error: credit underflow or ack while idle
module l15_req_arbiter
    import sargantana_hpdc_pkg::*;
#(
    parameter int unsigned NumPorts       = 6,
    parameter int unsigned PayloadWidth   = 128,
    parameter int unsigned AgeThreshold   = 16,
    parameter int unsigned MaxOutstanding = 4,
    parameter int unsigned IdxW           = (NumPorts > 1) ? $clog2(NumPorts) : 1
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [NumPorts-1:0]              req_valid_i,
    output logic [NumPorts-1:0]              req_ready_o,
    input  logic [NumPorts*PayloadWidth-1:0] req_payload_i,
    output logic                             l15_val_o,
    output logic [PayloadWidth-1:0]          l15_payload_o,
    output logic [IdxW-1:0]                  l15_portid_o,
    input  logic                             l15_ack_i,
    input  logic                             rtrn_valid_i,
    input  logic [IdxW-1:0]                  rtrn_portid_i,
    output logic [NumPorts-1:0]              urgent_o,
    output logic                             err_o
);

    localparam int unsigned CreditW = $clog2(MaxOutstanding + 1);
    localparam int unsigned AgeW    = $clog2(AgeThreshold + 1);

    arb_state_e              state_q, state_d;
    logic [PayloadWidth-1:0] payload_q, payload_d;
    logic [IdxW-1:0]         portid_q, portid_d;
    logic                    err_q, err_d;

    logic [NumPorts-1:0]     eligible;
    logic [NumPorts-1:0]     underflow;
    logic [NumPorts-1:0]     gnt;
    logic [IdxW-1:0]         gnt_idx;
    logic                    gnt_valid;
    logic                    ack_issue;

    logic [NumPorts-1:0][CreditW-1:0] credit_w;
    logic [NumPorts-1:0][AgeW-1:0]    age_w;

    // Only an ack seen while a request is in flight counts; an ack in
    // IDLE is flagged as an error and otherwise ignored.
    assign ack_issue = (state_q == ARB_ISSUE) && l15_ack_i;

    l15_arb_prio_sel #(
        .NumPorts (NumPorts),
        .IdxW     (IdxW)
    ) u_prio_sel (
        .eligible_i  (eligible),
        .urgent_i    (urgent_o),
        .gnt_o       (gnt),
        .gnt_idx_o   (gnt_idx),
        .gnt_valid_o (gnt_valid)
    );

    for (genvar p = 0; p < NumPorts; p++) begin : gen_port
        logic [CreditW-1:0] credit_q, credit_d;
        logic [AgeW-1:0]    age_q, age_d;
        logic               inc, dec, uflow;

        assign inc = ack_issue && (portid_q == IdxW'(p));
        assign dec = rtrn_valid_i && (rtrn_portid_i == IdxW'(p));

        always_comb begin
            credit_d = credit_q;
            uflow    = 1'b0;
            if (inc && !dec) begin
                if (credit_q != CreditW'(MaxOutstanding)) begin
                    credit_d = credit_q + CreditW'(1);
                end
            end else if (dec && !inc) begin
                if (credit_q == '0) begin
                    uflow = 1'b1;
                end else begin
                    credit_d = credit_q - CreditW'(1);
                end
            end
        end

        always_comb begin
            age_d = age_q;
            if (!req_valid_i[p] || req_ready_o[p]) begin
                age_d = '0;
            end else if ((state_q == ARB_IDLE) && eligible[p] &&
                         (age_q != AgeW'(AgeThreshold))) begin
                age_d = age_q + AgeW'(1);
            end
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                credit_q <= '0;
                age_q    <= '0;
            end else begin
                credit_q <= credit_d;
                age_q    <= age_d;
            end
        end

        assign eligible[p]  = req_valid_i[p] && (credit_q < CreditW'(MaxOutstanding));
        assign urgent_o[p]  = (age_q == AgeW'(AgeThreshold));
        assign underflow[p] = uflow;
        assign credit_w[p]  = credit_q;
        assign age_w[p]     = age_q;
    end

    always_comb begin
        state_d     = state_q;
        payload_d   = payload_q;
        portid_d    = portid_q;
        req_ready_o = '0;
        l15_val_o   = 1'b0;
        unique case (state_q)
            ARB_IDLE: begin
                if (gnt_valid) begin
                    req_ready_o = gnt;
                    portid_d    = gnt_idx;
                    for (int i = 0; i < int'(NumPorts); i++) begin
                        if (gnt[i]) begin
                            payload_d = req_payload_i[i*PayloadWidth +: PayloadWidth];
                        end
                    end
                    state_d = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                l15_val_o = 1'b1;
                if (l15_ack_i) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
        err_d = err_q | (|underflow) | ((state_q == ARB_IDLE) && l15_ack_i);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ARB_IDLE;
            payload_q <= '0;
            portid_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            payload_q <= payload_d;
            portid_q  <= portid_d;
            err_q     <= err_d;
        end
    end

    assign l15_payload_o = payload_q;
    assign l15_portid_o  = portid_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_l15_req_arbiter.sv
module tb_l15_req_arbiter;

    localparam int NP = 6;
    localparam int PW = 16;
    localparam int IW = 3;

    logic             clk;
    logic             rst;
    logic [NP-1:0]    req_valid;
    logic [NP-1:0]    req_ready;
    logic [NP*PW-1:0] req_payload;
    logic             l15_val;
    logic [PW-1:0]    l15_payload;
    logic [IW-1:0]    l15_portid;
    logic             l15_ack;
    logic             rtrn_valid;
    logic [IW-1:0]    rtrn_portid;
    logic [NP-1:0]    urgent;
    logic             err;

    int n_cmp;
    int n_bad;

    l15_req_arbiter #(
        .NumPorts       (NP),
        .PayloadWidth   (PW),
        .AgeThreshold   (4),
        .MaxOutstanding (4)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .req_payload_i (req_payload),
        .l15_val_o     (l15_val),
        .l15_payload_o (l15_payload),
        .l15_portid_o  (l15_portid),
        .l15_ack_i     (l15_ack),
        .rtrn_valid_i  (rtrn_valid),
        .rtrn_portid_i (rtrn_portid),
        .urgent_o      (urgent),
        .err_o         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_cmp       = 0;
        n_bad       = 0;
        rst         = 1'b1;
        req_valid   = '0;
        req_payload = '0;
        l15_ack     = 1'b0;
        rtrn_valid  = 1'b0;
        rtrn_portid = '0;
        for (int i = 0; i < NP; i++) req_payload[i*PW +: PW] = 16'h1111 * (i + 1);
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_val", l15_val, 0);
        chk("rst_payload", l15_payload, 0);
        chk("rst_portid", l15_portid, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_urgent", urgent, 0);
        chk("rst_err", err, 0);

        // Ports 1 and 3 together: 1 wins, then 3 after the ack.
        req_valid = 6'b001010;
        #1;
        chk("p13_ready1", req_ready, 6'b000010);
        tick();
        req_valid = 6'b001000;
        #1;
        chk("p13_val1", l15_val, 1);
        chk("p13_portid1", l15_portid, 1);
        chk("p13_payload1", l15_payload, 16'h2222);
        chk("p13_ready_issue", req_ready, 0);
        l15_ack = 1'b1;
        tick();
        l15_ack = 1'b0;
        #1;
        chk("p13_val_drop", l15_val, 0);
        chk("p13_ready3", req_ready, 6'b001000);
        tick();
        req_valid = '0;
        chk("p13_portid3", l15_portid, 3);
        chk("p13_payload3", l15_payload, 16'h4444);
        l15_ack = 1'b1;
        tick();
        l15_ack = 1'b0;
        rtrn_valid = 1'b1; rtrn_portid = 3'd1;
        tick();
        rtrn_portid = 3'd3;
        tick();
        rtrn_valid = 1'b0;
        chk("p13_err", err, 0);

        // Aging: port 0 always valid, port 5 waits until urgent.
        req_valid = 6'b100001;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("age_ready0", req_ready, 6'b000001);
            tick();
            rtrn_valid = 1'b0;
            chk("age_portid0", l15_portid, 0);
            chk("age_urgent", urgent, (k == 3) ? 6'b100000 : 6'b000000);
            l15_ack = 1'b1;
            tick();
            l15_ack = 1'b0;
            rtrn_valid = 1'b1; rtrn_portid = 3'd0;
        end
        #1;
        chk("age_ready5", req_ready, 6'b100000);
        tick();
        rtrn_valid = 1'b0;
        req_valid = 6'b000000;
        chk("age_portid5", l15_portid, 5);
        chk("age_urgent_clr", urgent, 0);
        l15_ack = 1'b1;
        tick();
        l15_ack = 1'b0;
        rtrn_valid = 1'b1; rtrn_portid = 3'd5;
        tick();
        rtrn_valid = 1'b0;
        chk("age_cred0", dut.credit_w[0], 0);
        chk("age_cred5", dut.credit_w[5], 0);

        // Credits: port 2 exhausts its four credits.
        req_valid = 6'b000100;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("cr_ready2", req_ready, 6'b000100);
            tick();
            l15_ack = 1'b1;
            tick();
            l15_ack = 1'b0;
        end
        req_valid = 6'b010100;
        #1;
        chk("cr_ready4", req_ready, 6'b010000);
        tick();
        req_valid = 6'b000100;
        chk("cr_portid4", l15_portid, 4);
        l15_ack = 1'b1;
        tick();
        l15_ack = 1'b0;
        #1;
        chk("cr_blocked", req_ready, 0);
        rtrn_valid = 1'b1; rtrn_portid = 3'd2;
        #1;
        chk("cr_blocked_rtrn", req_ready, 0);
        tick();
        rtrn_valid = 1'b0;
        #1;
        chk("cr_freed", req_ready, 6'b000100);
        tick();
        req_valid = '0;
        l15_ack = 1'b1;
        tick();
        l15_ack = 1'b0;
        chk("cr_cred2", dut.credit_w[2], 4);

        // Port 4 at credit 2: ack and return together leave it at 2.
        req_valid = 6'b010000;
        tick();
        req_valid = '0;
        l15_ack = 1'b1;
        tick();
        l15_ack = 1'b0;
        chk("both_pre", dut.credit_w[4], 2);
        req_valid = 6'b010000;
        tick();
        req_valid = '0;
        l15_ack = 1'b1;
        rtrn_valid = 1'b1; rtrn_portid = 3'd4;
        tick();
        l15_ack = 1'b0;
        rtrn_valid = 1'b0;
        chk("both_cred4", dut.credit_w[4], 2);
        chk("both_err", err, 0);
        chk("both_val", l15_val, 0);

        // Underflow on port 1, then a spurious ack while idle.
        rtrn_valid = 1'b1; rtrn_portid = 3'd1;
        tick();
        rtrn_valid = 1'b0;
        chk("uf_err", err, 1);
        chk("uf_cred1", dut.credit_w[1], 0);
        l15_ack = 1'b1;
        tick();
        l15_ack = 1'b0;
        chk("spur_err", err, 1);
        chk("spur_val", l15_val, 0);
        chk("spur_cred4", dut.credit_w[4], 2);

        // Reset while a request is in flight.
        req_payload[0 +: PW] = 16'hDEAD;
        req_valid = 6'b000001;
        tick();
        req_valid = '0;
        chk("rsti_payload", l15_payload, 16'hDEAD);
        chk("rsti_val", l15_val, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rsti_val0", l15_val, 0);
        chk("rsti_payload0", l15_payload, 0);
        chk("rsti_err0", err, 0);
        chk("rsti_credits", dut.credit_w, 0);
        chk("rsti_ages", dut.age_w, 0);
        chk("rsti_urgent", urgent, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
